// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, byte type and source select.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    SRC_ECHO = 1'b0,
    SRC_MSG  = 1'b1
  } src_t;

endpackage

// File: rtl/message_rom.sv
// Combinational message ROM: index -> byte of "HELLO!\r\n".
module message_rom
  import uart_pkg::*;
#(
  parameter int unsigned MSG_LEN = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [IDX_W-1:0] idx,
  output byte_t            data
);

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx);

  always_comb begin
    data = '0;
    if (idx_ext < MSG_LEN) begin
      case (idx_ext)
        32'd0:   data = 8'h48;
        32'd1:   data = 8'h45;
        32'd2:   data = 8'h4C;
        32'd3:   data = 8'h4C;
        32'd4:   data = 8'h4F;
        32'd5:   data = 8'h21;
        32'd6:   data = 8'h0D;
        32'd7:   data = 8'h0A;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a buffered echo path and a ROM message source,
// round-robin when both are pending. Optional watchdog: define UART_TX_SCHED_WD_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned ECHO_DEPTH = 4,
  parameter int unsigned WD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SW,
  input  logic [7:0] rx_word,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_word,
  output logic       tx_start,
  output logic [7:0] word,
  output logic       word_on_line,
  output logic       echo_overflow,
  output logic       tx_fault
);

  localparam int unsigned AW = $clog2(ECHO_DEPTH);
  localparam int unsigned IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  typedef logic [AW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;

  state_t state_q, state_d;
  src_t   last_src, grant_src;
  logic   grant, pop, push;
  logic   retry_q;
  idx_t   msg_idx;
  byte_t  rom_byte, fifo_head;

  // Echo FIFO; the extra pointer bit separates full from empty
  byte_t fifo_mem [ECHO_DEPTH];
  ptr_t  wr_ptr, rd_ptr;
  logic  fifo_empty, fifo_full;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
  assign push       = rx_valid && !fifo_full;
  assign pop        = grant && (grant_src == SRC_ECHO);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      echo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (rx_valid && fifo_full) echo_overflow <= 1'b1;
    end
  end

  message_rom #(
    .MSG_LEN(MSG_LEN),
    .IDX_W  (IW)
  ) u_rom (
    .idx (msg_idx),
    .data(rom_byte)
  );

`ifdef UART_TX_SCHED_WD_EN
  localparam int unsigned WDW = $clog2(WD_CYCLES + 1);
  typedef logic [WDW-1:0] wd_t;

  wd_t  wd_cnt;
  logic wd_expire, fault_q;

  assign wd_expire = (state_q == WAIT_BUSY) && tx_ready && (wd_cnt == wd_t'(WD_CYCLES - 1));
  assign tx_fault  = fault_q;

  // An aborted byte stays in tx_word and is replayed ahead of any new grant
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      retry_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= wd_expire;
      wd_cnt  <= (state_q == WAIT_BUSY) ? wd_cnt + wd_t'(1) : '0;
      if (wd_expire)                                    retry_q <= 1'b1;
      else if (state_q == IDLE && tx_ready && retry_q) retry_q <= 1'b0;
    end
  end
`else
  assign retry_q  = 1'b0;
  assign tx_fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_src = SRC_ECHO;
    case (state_q)
      IDLE: begin
        if (tx_ready) begin
          if (retry_q) begin
            state_d = START;
          end else if (!fifo_empty || SW) begin
            grant   = 1'b1;
            state_d = START;
            if (!fifo_empty && SW) grant_src = (last_src == SRC_ECHO) ? SRC_MSG : SRC_ECHO;
            else                   grant_src = fifo_empty ? SRC_MSG : SRC_ECHO;
          end
        end
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_ready) state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_WD_EN
        else if (wd_expire) state_d = IDLE;
`endif
      end
      WAIT_DONE: if (tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_word  <= '0;
      word     <= '0;
      last_src <= SRC_MSG;
      msg_idx  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        tx_word  <= (grant_src == SRC_ECHO) ? fifo_head : rom_byte;
        word     <= (grant_src == SRC_ECHO) ? fifo_head : rom_byte;
        last_src <= grant_src;
      end
      if (!SW)
        msg_idx <= '0;
      else if (grant && grant_src == SRC_MSG)
        msg_idx <= (msg_idx == idx_t'(MSG_LEN - 1)) ? '0 : msg_idx + idx_t'(1);
    end
  end

  assign tx_start     = (state_q == START);
  assign word_on_line = (state_q != IDLE);

endmodule
